// File: rtl/tl_pkg.sv
// Shared types, lamp codes and helpers for the intersection phase scheduler.
package tl_pkg;

   typedef enum logic [2:0] {
      S_CLEAR   = 3'd0,
      S_GREEN   = 3'd1,
      S_YELLOW  = 3'd2,
      S_WALK    = 3'd3,
      S_PREEMPT = 3'd4
   } state_t;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_t;

   // Requester identity; the value doubles as the bit index into the pending vector.
   typedef enum logic [1:0] {
      NS  = 2'd0,
      EW  = 2'd1,
      PED = 2'd2
   } req_id_t;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   // Lamp pattern shown on the 'me' head when the controller is in state s serving direction d.
   function automatic logic [2:0] lamp_for(input state_t s, input dir_t d, input dir_t me);
      logic [2:0] lamp;
      lamp = LAMP_RED;
      if (d == me) begin
         case (s)
            S_GREEN, S_PREEMPT: lamp = LAMP_GREEN;
            S_YELLOW:           lamp = LAMP_YELLOW;
            default:            lamp = LAMP_RED;
         endcase
      end
      return lamp;
   endfunction

   // Round-robin pick: first pending requester after 'last' in the order NS -> EW -> PED.
   // Callers only use the result when at least one pending bit is set.
   function automatic req_id_t rr_pick(input req_id_t last, input logic [2:0] pend);
      req_id_t pick;
      logic    found;
      int      idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         idx = (int'(last) + i) % 3;
         if (!found && pend[idx]) begin
            pick  = req_id_t'(idx[1:0]);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase interval timer: zeroed on every state change, counts up and saturates,
// and reports whether the count has reached the current state's threshold.
module tl_phase_timer #(
   parameter int TW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [TW-1:0] thresh,
   output logic [TW-1:0] count,
   output logic          ge
);

   // Count cycles spent in the current state, holding at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is assigned with <= so every register samples the
      // pre-edge values; blocking here would let later statements see updated state.
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + 1'b1;
      end
   end

   assign ge = (count >= thresh);

endmodule

// File: rtl/tl_phase_scheduler.sv
// Intersection phase scheduler: round-robin service of NS, EW and pedestrian
// requests with green/yellow/all-red/walk sequencing and emergency preemption.
// Lamp and walk outputs are registered from the next-state decode so a new
// state and its lamps appear on the same clock edge.
module tl_phase_scheduler
   import tl_pkg::*;
#(
   parameter int MIN_GREEN = 8,
   parameter int MAX_GREEN = 24,
   parameter int YELLOW_T  = 4,
   parameter int CLEAR_T   = 2,
   parameter int WALK_T    = 10,
   parameter int TW        = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_ns,
   input  logic       req_ew,
   input  logic       req_ped,
   input  logic       emg_req,
   input  logic       emg_dir,
   output logic [2:0] lights_ns,
   output logic [2:0] lights_ew,
   output logic       walk,
   output logic [2:0] phase,
   output logic [1:0] served
);

   // Last-cycle thresholds: a state of duration D leaves when the timer reads D-1.
   localparam logic [TW-1:0] CLEAR_LIM = TW'(CLEAR_T - 1);
   localparam logic [TW-1:0] MIN_LIM   = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] MAX_LIM   = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] YEL_LIM   = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] WALK_LIM  = TW'(WALK_T - 1);

   state_t        state_q, state_nx;
   dir_t          dir_q, dir_nx;
   req_id_t       served_q, served_nx;
   req_id_t       pick;
   logic [2:0]    pend_q, pend_nx;
   logic [2:0]    entry_clr;
   logic [2:0]    serving;
   logic [2:0]    own_bit;
   logic          own_req;
   logic          competitor;
   logic [TW-1:0] tmr_thresh;
   logic [TW-1:0] tmr_count;
   logic          tmr_ge;
   logic          tmr_clr;

   tl_phase_timer #(.TW(TW)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .thresh (tmr_thresh),
      .count  (tmr_count),
      .ge     (tmr_ge)
   );

   // Select the duration threshold that applies to the current state.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path through
      // the case leaves it unassigned, which would otherwise infer a latch.
      tmr_thresh = '0;
      case (state_q)
         S_CLEAR:  tmr_thresh = CLEAR_LIM;
         S_GREEN:  tmr_thresh = MIN_LIM;
         S_YELLOW: tmr_thresh = YEL_LIM;
         S_WALK:   tmr_thresh = WALK_LIM;
         default:  tmr_thresh = '0;
      endcase
   end

   // Next-state, direction, served and pending decode.
   always_comb begin
      state_nx  = state_q;
      dir_nx    = dir_q;
      served_nx = served_q;
      entry_clr = '0;
      pick      = rr_pick(served_q, pend_q);

      own_bit    = (dir_q == DIR_EW) ? 3'b010 : 3'b001;
      own_req    = (dir_q == DIR_EW) ? req_ew : req_ns;
      competitor = |(pend_q & ~own_bit);

      // A requester currently being served cannot re-arm its own pending bit.
      serving = '0;
      if (state_q == S_GREEN) serving = own_bit;
      if (state_q == S_WALK)  serving = 3'b100;

      case (state_q)
         S_CLEAR: begin
            if (tmr_ge) begin
               if (emg_req) begin
                  state_nx = S_PREEMPT;
                  dir_nx   = dir_t'(emg_dir);
               end else if (|pend_q) begin
                  served_nx = pick;
                  entry_clr[int'(pick)] = 1'b1;
                  if (pick == PED) begin
                     state_nx = S_WALK;
                  end else begin
                     state_nx = S_GREEN;
                     dir_nx   = (pick == EW) ? DIR_EW : DIR_NS;
                  end
               end
            end
         end
         S_GREEN: begin
            if (emg_req) begin
               // Same direction continues green without a lamp change.
               state_nx = (dir_t'(emg_dir) == dir_q) ? S_PREEMPT : S_YELLOW;
            end else if (competitor && ((tmr_ge && !own_req) || (tmr_count >= MAX_LIM))) begin
               state_nx = S_YELLOW;
            end
         end
         S_YELLOW: begin
            if (tmr_ge) state_nx = S_CLEAR;
         end
         S_WALK: begin
            if (emg_req || tmr_ge) state_nx = S_CLEAR;
         end
         S_PREEMPT: begin
            if (!emg_req || (dir_t'(emg_dir) != dir_q)) state_nx = S_YELLOW;
         end
         default: state_nx = S_CLEAR;
      endcase

      pend_nx = (pend_q | ({req_ped, req_ew, req_ns} & ~serving)) & ~entry_clr;
   end

   assign tmr_clr = (state_nx != state_q);

   // Register state, bookkeeping and lamp outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         dir_q     <= DIR_NS;
         served_q  <= PED;
         pend_q    <= '0;
         lights_ns <= LAMP_RED;
         lights_ew <= LAMP_RED;
         walk      <= 1'b0;
      end else begin
         state_q   <= state_nx;
         dir_q     <= dir_nx;
         served_q  <= served_nx;
         pend_q    <= pend_nx;
         lights_ns <= lamp_for(state_nx, dir_nx, DIR_NS);
         lights_ew <= lamp_for(state_nx, dir_nx, DIR_EW);
         walk      <= (state_nx == S_WALK);
      end
   end

   assign phase  = state_q;
   assign served = served_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed testbench for tl_phase_scheduler with default timing parameters.
module tb_tl_phase_scheduler;
   import tl_pkg::*;

   localparam int MIN_GREEN = 8;
   localparam int MAX_GREEN = 24;
   localparam int YELLOW_T  = 4;
   localparam int CLEAR_T   = 2;
   localparam int WALK_T    = 10;

   logic       clk;
   logic       rst_n;
   logic       req_ns, req_ew, req_ped, emg_req, emg_dir;
   logic [2:0] lights_ns, lights_ew, phase;
   logic       walk;
   logic [1:0] served;

   int tests_run    = 0;
   int tests_failed = 0;

   tl_phase_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_ns    (req_ns),
      .req_ew    (req_ew),
      .req_ped   (req_ped),
      .emg_req   (emg_req),
      .emg_dir   (emg_dir),
      .lights_ns (lights_ns),
      .lights_ew (lights_ew),
      .walk      (walk),
      .phase     (phase),
      .served    (served)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety invariants sampled on the falling edge throughout every test.
   always @(negedge clk) begin
      if (rst_n) begin
         assert (!(lights_ns !== LAMP_RED && lights_ew !== LAMP_RED)) else begin
            tests_failed++;
            $display("FAIL safety_both_nonred: ns=%b ew=%b", lights_ns, lights_ew);
         end
         assert (!(walk && (lights_ns !== LAMP_RED || lights_ew !== LAMP_RED))) else begin
            tests_failed++;
            $display("FAIL safety_walk_not_red: walk=%b ns=%b ew=%b", walk, lights_ns, lights_ew);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      {req_ns, req_ew, req_ped, emg_req, emg_dir} = '0;
      #2;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Count consecutive cycles (starting with the current one) whose outputs match.
   task automatic measure(input logic [2:0] ens, input logic [2:0] eew, input logic ewk,
                          input int limit, output int n);
      n = 0;
      while (lights_ns === ens && lights_ew === eew && walk === ewk && n < limit) begin
         n++;
         tick();
      end
   endtask

   // Advance until the outputs match, giving up after 'limit' cycles.
   task automatic wait_for(input logic [2:0] ens, input logic [2:0] eew, input logic ewk,
                           input int limit, output int n);
      n = 0;
      while (!(lights_ns === ens && lights_ew === eew && walk === ewk) && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int bad;
      int n;
      rst_n = 1'b0;
      {req_ns, req_ew, req_ped, emg_req, emg_dir} = '0;
      #2;
      tests_run++;
      if ({lights_ns, lights_ew, walk} !== {LAMP_RED, LAMP_RED, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_lamps: got ns=%b ew=%b walk=%b, want 100/100/0", lights_ns, lights_ew, walk);
      end
      tests_run++;
      if (phase !== 3'(S_CLEAR) || served !== 2'(PED)) begin
         tests_failed++;
         $display("FAIL reset_state: got phase=%0d served=%0d, want 0/2", phase, served);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         tick();
         if (lights_ns !== LAMP_RED || lights_ew !== LAMP_RED || walk !== 1'b0) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL idle_rest_red: %0d non-red cycles, want 0", bad);
      end
      req_ns = 1'b1;
      tick();
      req_ns = 1'b0;
      n = 1;
      while (lights_ns !== LAMP_GREEN && n < 10) begin
         tick();
         n++;
      end
      tests_run++;
      if (lights_ns !== LAMP_GREEN || n > CLEAR_T + 1) begin
         tests_failed++;
         $display("FAIL ns_pulse_latency: got ns=%b after %0d cycles, want 001 within %0d", lights_ns, n, CLEAR_T + 1);
      end
      tests_run++;
      if (served !== 2'(NS)) begin
         tests_failed++;
         $display("FAIL ns_pulse_served: got %0d want 0", served);
      end
      repeat (40) tick();
      tests_run++;
      if (lights_ns !== LAMP_GREEN || phase !== 3'(S_GREEN)) begin
         tests_failed++;
         $display("FAIL rest_in_green: got ns=%b phase=%0d, want 001/1", lights_ns, phase);
      end
   endtask

   task automatic test_max_green();
      int n;
      do_reset();
      req_ns = 1'b1;
      wait_for(LAMP_GREEN, LAMP_RED, 1'b0, 10, n);
      // Pulse EW during NS green cycle 0; the measurement below covers cycles 1..end.
      req_ew = 1'b1;
      tick();
      req_ew = 1'b0;
      measure(LAMP_GREEN, LAMP_RED, 1'b0, 60, n);
      tests_run++;
      if (n + 1 !== MAX_GREEN) begin
         tests_failed++;
         $display("FAIL max_green_len: got %0d cycles want %0d", n + 1, MAX_GREEN);
      end
      req_ns = 1'b0;
      measure(LAMP_YELLOW, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== YELLOW_T) begin
         tests_failed++;
         $display("FAIL max_green_yellow: got %0d want %0d", n, YELLOW_T);
      end
      measure(LAMP_RED, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== CLEAR_T) begin
         tests_failed++;
         $display("FAIL max_green_clear: got %0d want %0d", n, CLEAR_T);
      end
      tests_run++;
      if (lights_ew !== LAMP_GREEN || served !== 2'(EW)) begin
         tests_failed++;
         $display("FAIL max_green_ew_next: got ew=%b served=%0d, want 001/1", lights_ew, served);
      end
   endtask

   task automatic test_round_robin();
      int n;
      logic [1:0] s0, s1, s2;
      do_reset();
      {req_ns, req_ew, req_ped} = 3'b111;
      tick();
      {req_ns, req_ew, req_ped} = 3'b000;
      wait_for(LAMP_GREEN, LAMP_RED, 1'b0, 10, n);
      s0 = served;
      measure(LAMP_GREEN, LAMP_RED, 1'b0, 60, n);
      tests_run++;
      if (n !== MIN_GREEN) begin
         tests_failed++;
         $display("FAIL rr_ns_green: got %0d want %0d", n, MIN_GREEN);
      end
      measure(LAMP_YELLOW, LAMP_RED, 1'b0, 20, n);
      measure(LAMP_RED, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== CLEAR_T) begin
         tests_failed++;
         $display("FAIL rr_clear_after_ns: got %0d want %0d", n, CLEAR_T);
      end
      s1 = served;
      measure(LAMP_RED, LAMP_GREEN, 1'b0, 60, n);
      tests_run++;
      if (n !== MIN_GREEN) begin
         tests_failed++;
         $display("FAIL rr_ew_green: got %0d want %0d", n, MIN_GREEN);
      end
      measure(LAMP_RED, LAMP_YELLOW, 1'b0, 20, n);
      tests_run++;
      if (n !== YELLOW_T) begin
         tests_failed++;
         $display("FAIL rr_ew_yellow: got %0d want %0d", n, YELLOW_T);
      end
      measure(LAMP_RED, LAMP_RED, 1'b0, 20, n);
      s2 = served;
      measure(LAMP_RED, LAMP_RED, 1'b1, 40, n);
      tests_run++;
      if (n !== WALK_T) begin
         tests_failed++;
         $display("FAIL rr_walk_len: got %0d want %0d", n, WALK_T);
      end
      tests_run++;
      if ({s0, s1, s2} !== {2'd0, 2'd1, 2'd2}) begin
         tests_failed++;
         $display("FAIL rr_served_seq: got %0d,%0d,%0d want 0,1,2", s0, s1, s2);
      end
      tests_run++;
      if (phase !== 3'(S_CLEAR) || walk !== 1'b0) begin
         tests_failed++;
         $display("FAIL rr_after_walk: got phase=%0d walk=%b want 0/0", phase, walk);
      end
   endtask

   task automatic test_emg_preempt();
      int n;
      do_reset();
      {req_ns, req_ped} = 2'b11;
      tick();
      {req_ns, req_ped} = 2'b00;
      wait_for(LAMP_GREEN, LAMP_RED, 1'b0, 10, n);
      repeat (3) tick();
      emg_req = 1'b1;
      emg_dir = 1'b1;
      tick();
      tests_run++;
      if (lights_ns !== LAMP_YELLOW) begin
         tests_failed++;
         $display("FAIL emg_ns_yellow_now: got ns=%b want 010", lights_ns);
      end
      measure(LAMP_YELLOW, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== YELLOW_T) begin
         tests_failed++;
         $display("FAIL emg_ns_yellow_len: got %0d want %0d", n, YELLOW_T);
      end
      measure(LAMP_RED, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== CLEAR_T) begin
         tests_failed++;
         $display("FAIL emg_clear_len: got %0d want %0d", n, CLEAR_T);
      end
      measure(LAMP_RED, LAMP_GREEN, 1'b0, 20, n);
      tests_run++;
      if (n !== 20 || phase !== 3'(S_PREEMPT) || served !== 2'(NS)) begin
         tests_failed++;
         $display("FAIL emg_ew_hold: got %0d cycles phase=%0d served=%0d, want 20/4/0", n, phase, served);
      end
      emg_req = 1'b0;
      tick();
      measure(LAMP_RED, LAMP_YELLOW, 1'b0, 20, n);
      tests_run++;
      if (n !== YELLOW_T) begin
         tests_failed++;
         $display("FAIL emg_ew_yellow_len: got %0d want %0d", n, YELLOW_T);
      end
      measure(LAMP_RED, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== CLEAR_T || walk !== 1'b1 || served !== 2'(PED)) begin
         tests_failed++;
         $display("FAIL emg_then_ped: got clear=%0d walk=%b served=%0d, want 2/1/2", n, walk, served);
      end
   endtask

   task automatic test_emg_walk();
      int n;
      do_reset();
      req_ped = 1'b1;
      tick();
      req_ped = 1'b0;
      wait_for(LAMP_RED, LAMP_RED, 1'b1, 10, n);
      repeat (5) tick();
      emg_req = 1'b1;
      emg_dir = 1'b0;
      tick();
      tests_run++;
      if (walk !== 1'b0 || phase !== 3'(S_CLEAR)) begin
         tests_failed++;
         $display("FAIL emg_walk_drop: got walk=%b phase=%0d want 0/0", walk, phase);
      end
      measure(LAMP_RED, LAMP_RED, 1'b0, 20, n);
      tests_run++;
      if (n !== CLEAR_T) begin
         tests_failed++;
         $display("FAIL emg_walk_clear: got %0d want %0d", n, CLEAR_T);
      end
      tests_run++;
      if (lights_ns !== LAMP_GREEN || phase !== 3'(S_PREEMPT)) begin
         tests_failed++;
         $display("FAIL emg_walk_preempt: got ns=%b phase=%0d want 001/4", lights_ns, phase);
      end
      emg_req = 1'b0;
      tick();
      tests_run++;
      if (lights_ns !== LAMP_YELLOW) begin
         tests_failed++;
         $display("FAIL emg_walk_release: got ns=%b want 010", lights_ns);
      end
   endtask

   task automatic test_reset_mid_yellow();
      int n;
      do_reset();
      {req_ns, req_ew} = 2'b11;
      tick();
      {req_ns, req_ew} = 2'b00;
      wait_for(LAMP_GREEN, LAMP_RED, 1'b0, 10, n);
      measure(LAMP_GREEN, LAMP_RED, 1'b0, 60, n);
      repeat (2) tick();
      tests_run++;
      if (lights_ns !== LAMP_YELLOW) begin
         tests_failed++;
         $display("FAIL mid_yellow_setup: got ns=%b want 010", lights_ns);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({lights_ns, lights_ew, walk} !== {LAMP_RED, LAMP_RED, 1'b0} || phase !== 3'(S_CLEAR)) begin
         tests_failed++;
         $display("FAIL async_reset: got ns=%b ew=%b walk=%b phase=%0d want 100/100/0/0",
                  lights_ns, lights_ew, walk, phase);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_ew = 1'b1;
      tick();
      req_ew = 1'b0;
      wait_for(LAMP_RED, LAMP_GREEN, 1'b0, 10, n);
      tests_run++;
      if (lights_ew !== LAMP_GREEN || served !== 2'(EW) || n > CLEAR_T) begin
         tests_failed++;
         $display("FAIL resume_after_reset: got ew=%b served=%0d wait=%0d want 001/1/<=%0d",
                  lights_ew, served, n, CLEAR_T);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      {req_ns, req_ew, req_ped, emg_req, emg_dir} = '0;
      #2;
      test_reset();
      test_max_green();
      test_round_robin();
      test_emg_preempt();
      test_emg_walk();
      test_reset_mid_yellow();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tl_phase_scheduler.md
Name: tl_phase_scheduler

Overview:
- Intersection phase scheduler: grants right-of-way to NS vehicle, EW vehicle and pedestrian requesters in round-robin order, with emergency preemption.
- Sequences green, yellow, all-red clearance and walk intervals with parameterised minimum and maximum timing.
- Drives registered lamp and walk outputs for the intersection signal heads, replacing free-running light sequencing.

Parameters:
- MIN_GREEN, 8, minimum green cycles before a competing request can end a vehicle phase.
- MAX_GREEN, 24, green cycle cap when a competitor is pending and own request is held.
- YELLOW_T, 4, yellow interval cycles.
- CLEAR_T, 2, all-red clearance cycles.
- WALK_T, 10, pedestrian walk cycles.
- TW, 5, phase timer width; must satisfy 2**TW > max of all durations.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_ns  in  1  NS vehicle request (level or pulse)
- req_ew  in  1  EW vehicle request
- req_ped  in  1  pedestrian request
- emg_req  in  1  emergency preemption request, level
- emg_dir  in  1  preempt direction: 0=NS, 1=EW
- lights_ns  out  3  NS lamps {R,Y,G}, registered
- lights_ew  out  3  EW lamps {R,Y,G}, registered
- walk  out  1  pedestrian walk, registered
- phase  out  3  current state code (state_t)
- served  out  2  last served requester: 0=NS, 1=EW, 2=PED

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, applied immediately without a clock edge:
  - state=S_CLEAR, timer=0, pending=0, served=PED (so NS gets first priority).
  - lights_ns=lights_ew=3'b100, walk=0.
- Lamp encoding: red 3'b100, yellow 3'b010, green 3'b001.
- Outputs are registered from next state. A new state is visible on outputs in the same cycle the state register updates.
- Pending bits:
  - pend[x] is set when req_x=1.
  - pend[x] is cleared on entry to x's phase.
  - req_x is masked while x is being served (green, or walk for PED).
- Timer: up-counter, zeroed on every state change, saturates at 2**TW-1. A state with duration D occupies exactly D cycles.
- States:
  - S_CLEAR: both red.
    - Leaves when timer>=CLEAR_T-1.
    - emg_req=1 -> S_PREEMPT(emg_dir).
    - Otherwise, first pending requester after served in order NS->EW->PED -> S_GREEN(dir) or S_WALK.
    - With nothing pending, remains in S_CLEAR (rest in red) and re-evaluates every cycle.
  - S_GREEN(dir): dir green, other direction red.
    - -> S_YELLOW(dir) when a competitor is pending and either (timer>=MIN_GREEN-1 and own req low) or timer>=MAX_GREEN-1.
    - With no competitor, rests in green indefinitely.
  - S_YELLOW(dir): lasts YELLOW_T cycles, then -> S_CLEAR.
  - S_WALK: both red, walk=1 for WALK_T cycles, then -> S_CLEAR.
  - S_PREEMPT(d): d green, other red.
    - Holds while emg_req=1 and emg_dir==d.
    - When emg_req drops or emg_dir changes -> S_YELLOW(d).
- Emergency overrides (evaluated every cycle):
  - S_GREEN with dir!=emg_dir -> S_YELLOW next cycle, ignoring MIN_GREEN.
  - S_GREEN with dir==emg_dir -> S_PREEMPT, green continuous with no lamp glitch.
  - S_WALK -> S_CLEAR next cycle; walk drops in that cycle.
  - S_YELLOW completes its full interval.
- Preempt does not update served and does not clear pending bits.
- Safety invariants, held every cycle:
  - Lamps are never non-red in both directions.
  - walk=1 only when both directions are red.
  - Every yellow lasts exactly YELLOW_T cycles.
  - A clearance of at least CLEAR_T cycles precedes every green or walk.

Decomposition:
- Package tl_pkg:
  - state_t (S_CLEAR, S_GREEN, S_YELLOW, S_WALK, S_PREEMPT).
  - dir_t (DIR_NS, DIR_EW).
  - req_id_t (NS, EW, PED).
  - LAMP_RED, LAMP_YELLOW, LAMP_GREEN constants.
- One sub-module, tl_phase_timer: clear, count, saturate, and a >=threshold compare.
- Round-robin pick and FSM stay in the top module.

Test Plan:
- Reset release, no requests:
  - Lamps stay 3'b100/3'b100 and walk=0 for 50 cycles.
  - Single req_ns pulse -> lights_ns=3'b001 at most CLEAR_T+1 cycles later.
- req_ns held, req_ew pulse during NS green:
  - NS green lasts exactly 24 cycles, then 4 cycles of 3'b010, then 2 cycles of all-red.
  - Then lights_ew=3'b001.
- NS/EW/PED all pulsed during S_CLEAR, with own requests released:
  - Service order is NS green 8, EW green 8, then walk=1 for exactly 10 cycles.
  - served sequence is 0,1,2.
- emg_req=1, emg_dir=1 at NS green cycle 3:
  - Next cycle NS yellow for 4 cycles, clear for 2, then EW green held while emg_req stays high.
  - Drop emg_req -> EW yellow 4, clear 2, then earlier-pending PED served.
- emg_req during walk cycle 5:
  - walk=0 next cycle, clear for 2, then preempt green.
- rst_n low mid-yellow:
  - Outputs go to red/red with walk=0 before the next clk edge.
  - After release, resumes from S_CLEAR.
- Throughout all tests, an assertion checks that both directions are never non-red together.
